// File: rtl/mem_ctrl.sv
// LC-3b memory access controller: arbitrates fetch vs. data requests and
// sequences fixed-latency accesses to the byte-lane memory array.
module mem_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_rdy,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_rdy,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic        mem_we1,
  output logic        mem_we0,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        own_d, own_d_n;
  logic        r_we, r_we_n;
  logic        r_byte, r_byte_n;
  logic [15:0] r_addr, r_addr_n;
  logic [15:0] r_wd, r_wd_n;
  logic [15:0] rdata_n;
  logic        en_n, we1_n, we0_n;
  logic [15:0] maddr_n, mwd_n;
  logic        i_rdy_n, d_rdy_n;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    own_d_n  = own_d;
    r_we_n   = r_we;
    r_byte_n = r_byte;
    r_addr_n = r_addr;
    r_wd_n   = r_wd;
    rdata_n  = rdata;
    i_rdy_n  = 1'b0;
    d_rdy_n  = 1'b0;
    en_n     = 1'b0;
    we1_n    = 1'b0;
    we0_n    = 1'b0;
    maddr_n  = '0;
    mwd_n    = '0;
    unique case (state)
      IDLE: begin
        // data port has fixed priority over fetch
        if (d_req) begin
          own_d_n  = 1'b1;
          r_addr_n = d_addr;
          r_we_n   = d_we;
          r_byte_n = d_byte;
          r_wd_n   = d_wdata;
          state_n  = ACCESS;
          cnt_n    = CNT_INIT;
        end else if (i_req) begin
          own_d_n  = 1'b0;
          r_addr_n = i_addr;
          r_we_n   = 1'b0;
          r_byte_n = 1'b0;
          r_wd_n   = '0;
          state_n  = ACCESS;
          cnt_n    = CNT_INIT;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_n = DONE;
          if (r_byte && !r_we)
            rdata_n = {8'h00, r_addr[0] ? mem_rdata[15:8]
                                        : mem_rdata[7:0]};
          else
            rdata_n = mem_rdata;
          i_rdy_n = !own_d;
          d_rdy_n = own_d;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // memory-side outputs are registered from the next-state view
    if (state_n == ACCESS) begin
      en_n    = 1'b1;
      maddr_n = {r_addr_n[15:1], 1'b0};
      we1_n   = r_we_n && (!r_byte_n || r_addr_n[0]);
      we0_n   = r_we_n && (!r_byte_n || !r_addr_n[0]);
      if (r_we_n)
        mwd_n = r_byte_n ? {r_wd_n[7:0], r_wd_n[7:0]} : r_wd_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      own_d     <= 1'b0;
      r_we      <= 1'b0;
      r_byte    <= 1'b0;
      r_addr    <= '0;
      r_wd      <= '0;
      rdata     <= '0;
      i_rdy     <= 1'b0;
      d_rdy     <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_we1   <= 1'b0;
      mem_we0   <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      own_d     <= own_d_n;
      r_we      <= r_we_n;
      r_byte    <= r_byte_n;
      r_addr    <= r_addr_n;
      r_wd      <= r_wd_n;
      rdata     <= rdata_n;
      i_rdy     <= i_rdy_n;
      d_rdy     <= d_rdy_n;
      mem_en    <= en_n;
      mem_addr  <= maddr_n;
      mem_we1   <= we1_n;
      mem_we0   <= we0_n;
      mem_wdata <= mwd_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (LATENCY 4 and 1) on shared stimulus,
// checked every cycle against a grant-timeline model plus literal vectors.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic        d_byte = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] mem_rdata = '0;

  logic        i_rdy_w [2];
  logic        d_rdy_w [2];
  logic [15:0] rdata_w [2];
  logic        busy_w  [2];
  logic        en_w    [2];
  logic [15:0] maddr_w [2];
  logic        we1_w   [2];
  logic        we0_w   [2];
  logic [15:0] mwd_w   [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.LATENCY(4)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy_w[0]),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdy(d_rdy_w[0]),
    .rdata(rdata_w[0]), .busy(busy_w[0]),
    .mem_en(en_w[0]), .mem_addr(maddr_w[0]),
    .mem_we1(we1_w[0]), .mem_we0(we0_w[0]),
    .mem_wdata(mwd_w[0]), .mem_rdata(mem_rdata)
  );

  mem_ctrl #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy_w[1]),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdy(d_rdy_w[1]),
    .rdata(rdata_w[1]), .busy(busy_w[1]),
    .mem_en(en_w[1]), .mem_addr(maddr_w[1]),
    .mem_we1(we1_w[1]), .mem_we0(we0_w[1]),
    .mem_wdata(mwd_w[1]), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input int k,
                     input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Model: each instance is a timeline of grant edges.
  int          ecnt = 0;
  bit          act   [2];
  int          gnt   [2];
  bit          own_d [2];
  bit          m_we  [2];
  bit          m_byt [2];
  logic [15:0] m_adr [2];
  logic [15:0] m_wd  [2];
  logic [15:0] m_rd  [2];

  always @(posedge clk) begin
    ecnt++;
    for (int k = 0; k < 2; k++) begin
      int l;
      l = lat_of(k);
      if (rst) begin
        act[k]  = 1'b0;
        m_rd[k] = '0;
      end else if (act[k]) begin
        if (ecnt == gnt[k] + l) begin
          if (own_d[k] && m_byt[k] && !m_we[k])
            m_rd[k] = m_adr[k][0] ? (mem_rdata >> 8)
                                  : (mem_rdata & 16'h00FF);
          else
            m_rd[k] = mem_rdata;
        end
        if (ecnt == gnt[k] + l + 1) act[k] = 1'b0;
      end else if (d_req || i_req) begin
        act[k]   = 1'b1;
        gnt[k]   = ecnt;
        own_d[k] = d_req;
        m_adr[k] = d_req ? d_addr : i_addr;
        m_we[k]  = d_req && d_we;
        m_byt[k] = d_req && d_byte;
        m_wd[k]  = d_wdata;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      int l;
      bit acc, done;
      logic [15:0] e_adr, e_wd;
      logic e_w1, e_w0;
      l    = lat_of(k);
      acc  = act[k] && ecnt >= gnt[k] && ecnt <= gnt[k] + l - 1;
      done = act[k] && ecnt == gnt[k] + l;
      e_adr = acc ? (m_adr[k] & 16'hFFFE) : 16'h0;
      e_w1  = acc && m_we[k] && (!m_byt[k] || m_adr[k][0]);
      e_w0  = acc && m_we[k] && (!m_byt[k] || !m_adr[k][0]);
      e_wd  = '0;
      if (acc && m_we[k])
        e_wd = m_byt[k] ? {m_wd[k][7:0], m_wd[k][7:0]} : m_wd[k];
      chk("i_rdy", k, i_rdy_w[k], done && !own_d[k]);
      chk("d_rdy", k, d_rdy_w[k], done && own_d[k]);
      chk("rdy_excl", k, i_rdy_w[k] & d_rdy_w[k], 0);
      chk("busy", k, busy_w[k], act[k]);
      chk("rdata", k, rdata_w[k], m_rd[k]);
      chk("mem_en", k, en_w[k], acc);
      chk("mem_addr", k, maddr_w[k], e_adr);
      chk("mem_we1", k, we1_w[k], e_w1);
      chk("mem_we0", k, we0_w[k], e_w0);
      chk("mem_wdata", k, mwd_w[k], e_wd);
    end
  end

  // One request on the LATENCY=4 instance, observed until its rdy.
  task automatic do_req(input bit is_d, input bit we, input bit byt,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] mr,
                        output int lat, output int en_n,
                        output logic [15:0] a_s, output logic w1,
                        output logic w0, output logic [15:0] wd_s);
    bit got;
    @(negedge clk);
    mem_rdata = mr;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_byte = byt;
      d_addr = addr; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    lat = 0; en_n = 0; a_s = '0; w1 = 1'b0; w0 = 1'b0; wd_s = '0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (en_w[0]) begin
        en_n++;
        a_s = maddr_w[0];
        w1 = w1 | we1_w[0];
        w0 = w0 | we0_w[0];
        wd_s = mwd_w[0];
      end
      if (is_d ? d_rdy_w[0] : i_rdy_w[0]) got = 1'b1;
    end
    if (!got) chk("rdy_timeout", 0, 0, 1);
    @(negedge clk);
    d_req = 1'b0; i_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, en_n, n, e, last;
    logic [15:0] a_s, wd_s, a_cap;
    logic w1, w0;
    logic [15:0] b2b_in  [3];
    logic [15:0] b2b_exp [3];
    b2b_in  = '{16'h1001, 16'h2003, 16'h3004};
    b2b_exp = '{16'h1000, 16'h2002, 16'h3004};

    repeat (2) @(negedge clk);
    chk("rst_busy", 0, busy_w[0], 0);
    chk("rst_rdata", 0, rdata_w[0], 16'h0);
    chk("rst_en", 0, en_w[0], 0);
    chk("rst_addr", 0, maddr_w[0], 16'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_req(0, 0, 0, 16'h3001, 16'h0, 16'hBEEF, lat, en_n, a_s, w1, w0, wd_s);
    chk("fetch_lat", 0, 16'(lat), 16'd5);
    chk("fetch_en_cycles", 0, 16'(en_n), 16'd4);
    chk("fetch_addr", 0, a_s, 16'h3000);
    chk("fetch_we", 0, {14'h0, w1, w0}, 16'h0);
    chk("fetch_rdata", 0, rdata_w[0], 16'hBEEF);

    do_req(1, 1, 1, 16'h4001, 16'h00A5, 16'h0, lat, en_n, a_s, w1, w0, wd_s);
    chk("sb_hi_we", 0, {14'h0, w1, w0}, 16'h2);
    chk("sb_hi_wdata", 0, wd_s, 16'hA5A5);
    chk("sb_hi_addr", 0, a_s, 16'h4000);
    chk("sb_lat", 0, 16'(lat), 16'd5);

    do_req(1, 1, 1, 16'h4000, 16'h00A5, 16'h0, lat, en_n, a_s, w1, w0, wd_s);
    chk("sb_lo_we", 0, {14'h0, w1, w0}, 16'h1);

    do_req(1, 1, 0, 16'h4000, 16'h1234, 16'h0, lat, en_n, a_s, w1, w0, wd_s);
    chk("sw_we", 0, {14'h0, w1, w0}, 16'h3);
    chk("sw_wdata", 0, wd_s, 16'h1234);

    do_req(1, 0, 1, 16'h4003, 16'h0, 16'h80FF, lat, en_n, a_s, w1, w0, wd_s);
    chk("lb_hi", 0, rdata_w[0], 16'h0080);
    chk("lb_hi_we", 0, {14'h0, w1, w0}, 16'h0);

    do_req(1, 0, 1, 16'h4002, 16'h0, 16'h80FF, lat, en_n, a_s, w1, w0, wd_s);
    chk("lb_lo", 0, rdata_w[0], 16'h00FF);

    do_req(1, 0, 0, 16'h4003, 16'h0, 16'h1234, lat, en_n, a_s, w1, w0, wd_s);
    chk("lw_addr", 0, a_s, 16'h4002);
    chk("lw_rdata", 0, rdata_w[0], 16'h1234);

    // simultaneous requests: D first, I in the IDLE cycle after d_rdy
    repeat (3) @(negedge clk);
    mem_rdata = 16'hCAFE;
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h6000;
    i_req = 1'b1; i_addr = 16'h7000;
    n = 0;
    while (!d_rdy_w[0] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("prio_d_lat", 0, 16'(n), 16'd5);
    chk("prio_i_not_yet", 0, i_rdy_w[0], 0);
    @(negedge clk);
    d_req = 1'b0;
    n = 0;
    while (!i_rdy_w[0] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("prio_i_gap", 0, 16'(n), 16'd6);
    chk("prio_i_rdata", 0, rdata_w[0], 16'hCAFE);
    @(negedge clk);
    i_req = 1'b0;

    // asynchronous reset during the second ACCESS cycle of a word store
    repeat (3) @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_byte = 1'b0;
    d_addr = 16'h5000; d_wdata = 16'h1234;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_we1", 0, we1_w[0], 1);
    chk("pre_rst_en", 0, en_w[0], 1);
    rst = 1'b1;
    #1;
    chk("async_en", 0, en_w[0], 0);
    chk("async_we", 0, {14'h0, we1_w[0], we0_w[0]}, 16'h0);
    chk("async_busy", 0, busy_w[0], 0);
    chk("async_rdy", 0, {14'h0, i_rdy_w[0], d_rdy_w[0]}, 16'h0);
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_req(0, 0, 0, 16'h0100, 16'h0, 16'h5555, lat, en_n, a_s, w1, w0, wd_s);
    chk("post_rst_lat", 0, 16'(lat), 16'd5);
    chk("post_rst_rdata", 0, rdata_w[0], 16'h5555);

    // back-to-back fetches on the LATENCY=1 instance, i_req held high
    repeat (6) @(negedge clk);
    mem_rdata = 16'h0F0F;
    i_req = 1'b1; i_addr = b2b_in[0];
    n = 0; e = 0; last = 0; a_cap = '0;
    while (n < 3 && e < 60) begin
      @(posedge clk); #1; e++;
      if (en_w[1]) a_cap = maddr_w[1];
      if (i_rdy_w[1]) begin
        if (n == 0) chk("b2b_first", 1, 16'(e), 16'd2);
        else chk("b2b_period", 1, 16'(e - last), 16'd3);
        chk("b2b_addr", 1, a_cap, b2b_exp[n]);
        last = e;
        n++;
        @(negedge clk);
        if (n < 3) i_addr = b2b_in[n];
      end
    end
    if (n < 3) chk("b2b_timeout", 1, 16'(n), 16'd3);
    i_req = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access controller between the LC-3b datapath and the byte-lane memory array. It arbitrates between an instruction-fetch port and a data (load/store) port, and converts each granted request into a word-aligned address plus per-byte write enables. It sequences a fixed-latency access and returns a one-cycle ready pulse, equivalent to the LC-3b R signal, to the winning requester.

## Interface
- LATENCY, 4: memory cycles per access. Legal range 1..15.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request. Word read only.
- i_addr  in  16  fetch byte address.
- i_rdy  out  1  one-cycle pulse: fetch complete.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_byte  in  1  1 = byte access, 0 = word access.
- d_addr  in  16  data byte address.
- d_wdata  in  16  store data. For byte stores, the data is in [7:0].
- d_rdy  out  1  one-cycle pulse: data access complete.
- rdata  out  16  read result, valid with i_rdy or d_rdy.
- busy  out  1  high whenever the state is not IDLE.
- mem_en  out  1  memory access strobe.
- mem_addr  out  16  word-aligned address.
- mem_we1  out  1  write enable, high byte [15:8].
- mem_we0  out  1  write enable, low byte [7:0].
- mem_wdata  out  16  write data to memory.
- mem_rdata  in  16  memory read data. Valid in the last ACCESS cycle.

## Operation
- States:
  - IDLE: waiting for a request.
  - ACCESS: memory cycles in progress, with cnt running from LATENCY-1 down to 0.
  - DONE: completion cycle.
- IDLE transitions:
  - If d_req=1, grant D. Data has fixed priority over fetch.
  - Else if i_req=1, grant I.
  - Else stay in IDLE.
  - On a grant, register the owner, the address and the access type, then go to ACCESS with cnt=LATENCY-1.
- ACCESS behaviour:
  - mem_en=1.
  - Write enables:
    - Word store: we1=we0=1.
    - Byte store with addr[0]=0: we0 only.
    - Byte store with addr[0]=1: we1 only.
    - Load or fetch: both enables 0.
  - When cnt=0: capture read data and go to DONE.
  - Otherwise: cnt decrements.
- DONE behaviour:
  - Pulse rdy to the owner for exactly one cycle, then go to IDLE.
- Address rule: mem_addr = {reg_addr[15:1],1'b0} for all accesses. For word accesses, address bit 0 is ignored.
- mem_wdata:
  - Word store: d_wdata.
  - Byte store: {d_wdata[7:0], d_wdata[7:0]}.
  - Loads and fetches: 0.
- rdata:
  - Word access: mem_rdata.
  - Byte load: {8'h00, selected byte}, where addr[0]=0 selects [7:0] and addr[0]=1 selects [15:8]. Sign extension is done by the datapath.
  - rdata is registered and holds until the next completion.
- Request fields are sampled only at grant. Later changes to a requester's fields during its access have no effect.
- A requester must hold req until its rdy. If req drops mid-access, the controller still completes the access and pulses rdy.
- The losing requester stays pending. It is granted in the IDLE cycle following DONE unless d_req is still high.

## Timing
- Reset values:
  - state=IDLE, cnt=0.
  - i_rdy=d_rdy=0, busy=0, rdata=0.
  - mem_en=mem_we1=mem_we0=0, mem_addr=0, mem_wdata=0.
- Grant occurs on the edge where req is high in IDLE (edge t).
- ACCESS occupies cycles t+1 .. t+LATENCY.
- rdy is high in cycle t+LATENCY+1, so request-to-rdy latency is LATENCY+1 cycles.
- Minimum IDLE gap between accesses is 1 cycle, giving LATENCY+2 cycles per access.
- A requester must deassert or change req in the rdy cycle. A req still high in the IDLE cycle after rdy is treated as a new request.
- All memory-side outputs are registered and stable for the whole ACCESS window. They are forced to 0 in IDLE and DONE.
- Asynchronous rst mid-ACCESS:
  - Immediately aborts the access and returns to IDLE.
  - Drops mem_en and both write enables in the same cycle.
  - No rdy is issued for the aborted request.
- LATENCY=1 is legal: ACCESS lasts one cycle and rdy comes 2 cycles after grant.

## Test plan
- Reset, then word fetch, LATENCY=4:
  - Stimulus: i_addr=16'h3001, mem_rdata=16'hBEEF.
  - Required: mem_addr=16'h3000 with mem_en high for 4 cycles, no write enables, i_rdy pulses 5 cycles after grant, rdata=16'hBEEF.
- Byte stores:
  - Stimulus: d_addr=16'h4001, d_wdata=16'h00A5, d_byte=1, d_we=1.
  - Required: mem_we1=1, mem_we0=0, mem_wdata=16'hA5A5.
  - Repeat at d_addr=16'h4000: required mem_we0 only.
- Byte load:
  - Stimulus: addr[0]=1, mem_rdata=16'h80FF.
  - Required: rdata=16'h0080.
  - Same with addr[0]=0: required rdata=16'h00FF.
- Simultaneous i_req and d_req in IDLE:
  - Required: D is served first.
  - I is granted in the IDLE cycle after d_rdy.
  - Exactly one rdy pulse per request.
  - i_rdy and d_rdy are never high together.
- Reset asserted at ACCESS cycle 2:
  - Required: mem_en, we1 and we0 go low without a clock edge.
  - No rdy pulse.
  - busy=0.
  - A fresh request after reset completes normally.
- Back-to-back fetches with i_req held high and LATENCY=1:
  - Required: i_rdy every 3 cycles.
  - mem_addr follows each new i_addr sampled at grant.
